// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the Y86 execute-stage controller.
package exec_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] ADDQ = 4'd0;
  localparam logic [3:0] SUBQ = 4'd1;
  localparam logic [3:0] ANDQ = 4'd2;
  localparam logic [3:0] XORQ = 4'd3;
  localparam logic [1:0] AOK = 2'd0;
  localparam logic [1:0] HLT = 2'd1;
  localparam logic [1:0] INS = 2'd2;
  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;
  typedef enum logic {RUN, HALTED} state_t;
endpackage

// File: rtl/exec_cond.sv
// exec_cond: jXX/cmovXX condition evaluation from the CC register.
module exec_cond
  import exec_pkg::*;
(
  input  logic [3:0] ifun_i,
  input  logic [2:0] cc_i,
  output logic       cnd_o,
  output logic       ok_o
);
  logic lt, zf;
  assign lt   = cc_i[SF] ^ cc_i[OF];
  assign zf   = cc_i[ZF];
  assign ok_o = ifun_i <= 4'd6;
  always_comb
    cnd_o = ifun_i == 4'd1 ? lt | zf :
            ifun_i == 4'd2 ? lt :
            ifun_i == 4'd3 ? zf :
            ifun_i == 4'd4 ? !zf :
            ifun_i == 4'd5 ? !lt :
            ifun_i == 4'd6 ? !lt & !zf : 1'b1;
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: Y86 execute-stage controller; optional cc_hold port via EXEC_CC_HOLD_EN.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_icode,
  input  logic [3:0]   in_ifun,
  input  logic [W-1:0] in_vala,
  input  logic [W-1:0] in_valb,
  input  logic [W-1:0] in_valc,
  output logic [3:0]   alu_fn,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_y,
  input  logic [2:0]   alu_cc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_icode,
  output logic [W-1:0] out_vale,
  output logic [W-1:0] out_vala,
  output logic         out_cnd,
  output logic [1:0]   out_stat,
`ifdef EXEC_CC_HOLD_EN
  input  logic         cc_hold,
`endif
  output logic [2:0]   cc_q
);
  localparam logic [W-1:0] POS8 = W'(8);
  localparam logic [W-1:0] NEG8 = ~W'(7);
  state_t state_q, state_d;
  logic out_valid_q, out_valid_d, out_cnd_q, out_cnd_d;
  logic [3:0] out_icode_q, out_icode_d;
  logic [W-1:0] out_vale_q, out_vale_d, out_vala_q, out_vala_d;
  logic [1:0] out_stat_q, out_stat_d;
  logic [2:0] cc_d;
  logic is_op, is_cj, cond_ok, cond_cnd, bad, zero_e, accept, hold, stop;
`ifdef EXEC_CC_HOLD_EN
  assign hold = cc_hold;
`else
  assign hold = 1'b0;
`endif
  exec_cond u_cond (
    .ifun_i(in_ifun),
    .cc_i  (cc_q),
    .cnd_o (cond_cnd),
    .ok_o  (cond_ok)
  );
  assign is_op  = in_icode == IOPQ;
  assign is_cj  = in_icode == IJXX || in_icode == IRRMOVQ;
  assign bad    = in_icode > IPOPQ ||
                  (is_op ? in_ifun > XORQ : is_cj ? !cond_ok : in_ifun != 4'd0);
  assign zero_e = bad || in_icode == IHALT || in_icode == INOP || in_icode == IJXX;
  assign accept = in_valid & in_ready;
  assign stop   = bad || in_icode == IHALT;
  assign alu_fn = is_op && !bad ? in_ifun : ADDQ;
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (in_icode)
      IRRMOVQ:          alu_a = in_vala;
      IIRMOVQ:          alu_a = in_valc;
      IRMMOVQ, IMRMOVQ: begin alu_a = in_valc; alu_b = in_valb; end
      IOPQ:             begin alu_a = in_vala; alu_b = in_valb; end
      ICALL, IPUSHQ:    begin alu_a = NEG8;    alu_b = in_valb; end
      IRET, IPOPQ:      begin alu_a = POS8;    alu_b = in_valb; end
      default:          ;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  always_comb
    state_d = state_q == RUN && accept && stop ? HALTED : state_q;
  always_comb
    in_ready = state_q == RUN && (!out_valid_q || out_ready);
  always_comb begin
    out_valid_d = accept ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_icode_d = accept ? in_icode : out_icode_q;
    out_vale_d  = accept ? (zero_e ? '0 : alu_y) : out_vale_q;
    out_vala_d  = accept ? in_vala : out_vala_q;
    out_cnd_d   = accept ? (is_cj ? cond_cnd : 1'b1) : out_cnd_q;
    out_stat_d  = accept ? (bad ? INS : in_icode == IHALT ? HLT : AOK) : out_stat_q;
    cc_d        = accept && is_op && !bad && !hold ? alu_cc : cc_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_icode_q <= INOP;
      out_vale_q  <= '0;
      out_vala_q  <= '0;
      out_cnd_q   <= 1'b0;
      out_stat_q  <= AOK;
      cc_q        <= 3'b100;
    end else begin
      out_valid_q <= out_valid_d;
      out_icode_q <= out_icode_d;
      out_vale_q  <= out_vale_d;
      out_vala_q  <= out_vala_d;
      out_cnd_q   <= out_cnd_d;
      out_stat_q  <= out_stat_d;
      cc_q        <= cc_d;
    end
  assign out_valid = out_valid_q;
  assign out_icode = out_icode_q;
  assign out_vale  = out_vale_q;
  assign out_vala  = out_vala_q;
  assign out_cnd   = out_cnd_q;
  assign out_stat  = out_stat_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed vectors for exec_ctrl with a behavioural ALU mux.
module tb_exec_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_cnd;
  logic [3:0] in_icode = 4'h1, in_ifun = 4'h0, alu_fn, out_icode;
  logic [63:0] in_vala = '0, in_valb = '0, in_valc = '0, alu_a, alu_b, alu_y, out_vale, out_vala;
  logic [2:0] alu_cc = '0, cc_q;
  logic [1:0] out_stat;
`ifdef EXEC_CC_HOLD_EN
  logic cc_hold = 1'b0;
`endif
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  exec_ctrl #(.W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_vala(in_vala), .in_valb(in_valb),
    .in_valc(in_valc), .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_cc(alu_cc), .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_vale(out_vale), .out_vala(out_vala), .out_cnd(out_cnd), .out_stat(out_stat),
`ifdef EXEC_CC_HOLD_EN
    .cc_hold(cc_hold),
`endif
    .cc_q(cc_q)
  );
  always_comb
    alu_y = alu_fn == 4'd0 ? alu_a + alu_b :
            alu_fn == 4'd1 ? alu_b - alu_a :
            alu_fn == 4'd2 ? alu_a & alu_b : alu_a ^ alu_b;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] va,
                       input logic [63:0] vb, input logic [63:0] vc, input logic [2:0] cc);
    in_valid = 1'b1;
    in_icode = ic;
    in_ifun  = fn;
    in_vala  = va;
    in_valb  = vb;
    in_valc  = vc;
    alu_cc   = cc;
    #1;
  endtask
  task automatic reset;
    rst = 1'b1;
    in_valid = 1'b0;
    tick;
    rst = 1'b0;
  endtask
  initial begin
    reset;
    tick;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_icode", 64'(out_icode), 64'd1);
    chk("rst_vale", out_vale, 64'd0);
    chk("rst_cnd", 64'(out_cnd), 64'd0);
    chk("rst_stat", 64'(out_stat), 64'd0);
    chk("rst_cc", 64'(cc_q), 64'd4);
    chk("rst_ready", 64'(in_ready), 64'd1);
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 3'b100);
    chk("sub_fn", 64'(alu_fn), 64'd1);
    chk("sub_a", alu_a, 64'd5);
    chk("sub_b", alu_b, 64'd5);
    tick;
    chk("sub_valid", 64'(out_valid), 64'd1);
    chk("sub_vale", out_vale, 64'd0);
    chk("sub_stat", 64'(out_stat), 64'd0);
    chk("sub_cnd", 64'(out_cnd), 64'd1);
    chk("sub_cc", 64'(cc_q), 64'd4);
    drive(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 3'b010);
    chk("add_fn", 64'(alu_fn), 64'd0);
    tick;
    chk("add_vale", out_vale, 64'd7);
    chk("add_cc", 64'(cc_q), 64'd2);
    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 3'b111);
    tick;
    chk("jl_cnd", 64'(out_cnd), 64'd1);
    chk("jl_vale", out_vale, 64'd0);
    chk("jl_icode", 64'(out_icode), 64'd7);
    chk("jl_cc", 64'(cc_q), 64'd2);
    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 3'b111);
    tick;
    chk("je_cnd", 64'(out_cnd), 64'd0);
    drive(4'hA, 4'h0, 64'h55, 64'h100, 64'd0, 3'b111);
    chk("push_a", alu_a, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("push_b", alu_b, 64'h100);
    chk("push_fn", 64'(alu_fn), 64'd0);
    tick;
    chk("push_vale", out_vale, 64'hF8);
    chk("push_vala", out_vala, 64'h55);
    chk("push_cc", 64'(cc_q), 64'd2);
    drive(4'h9, 4'h0, 64'd0, 64'h100, 64'd0, 3'b111);
    chk("ret_a", alu_a, 64'd8);
    tick;
    chk("ret_vale", out_vale, 64'h108);
    drive(4'h2, 4'h4, 64'h77, 64'h99, 64'd0, 3'b111);
    chk("cmov_b", alu_b, 64'd0);
    tick;
    chk("cmov_cnd", 64'(out_cnd), 64'd1);
    chk("cmov_vale", out_vale, 64'h77);
    drive(4'h3, 4'h0, 64'd0, 64'h99, 64'h1234, 3'b111);
    tick;
    chk("irmov_vale", out_vale, 64'h1234);
    out_ready = 1'b0;
    drive(4'h5, 4'h0, 64'd0, 64'h20, 64'h10, 3'b111);
    chk("stall_ready", 64'(in_ready), 64'd0);
    chk("mrmov_a", alu_a, 64'h10);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_icode", 64'(out_icode), 64'd3);
      chk("stall_vale", out_vale, 64'h1234);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("rel_ready", 64'(in_ready), 64'd1);
    tick;
    chk("rel_icode", 64'(out_icode), 64'd5);
    chk("rel_vale", out_vale, 64'h30);
    drive(4'h4, 4'h0, 64'd0, 64'd2, 64'd1, 3'b111);
    tick;
    chk("rmmov_vale", out_vale, 64'd3);
    chk("rmmov_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick;
    chk("drain_valid", 64'(out_valid), 64'd0);
    drive(4'hC, 4'h0, 64'd9, 64'd9, 64'd9, 3'b001);
    tick;
    chk("ins_stat", 64'(out_stat), 64'd2);
    chk("ins_vale", out_vale, 64'd0);
    chk("ins_valid", 64'(out_valid), 64'd1);
    chk("ins_cc", 64'(cc_q), 64'd2);
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 3'b001);
    chk("ins_ready", 64'(in_ready), 64'd0);
    tick;
    chk("ins_drain", 64'(out_valid), 64'd0);
    chk("ins_hold_cc", 64'(cc_q), 64'd2);
    chk("ins_ready2", 64'(in_ready), 64'd0);
    reset;
    chk("rst2_ready", 64'(in_ready), 64'd1);
    chk("rst2_cc", 64'(cc_q), 64'd4);
    chk("rst2_valid", 64'(out_valid), 64'd0);
    drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 3'b001);
    tick;
    chk("halt_stat", 64'(out_stat), 64'd1);
    chk("halt_icode", 64'(out_icode), 64'd0);
    chk("halt_ready", 64'(in_ready), 64'd0);
    reset;
    drive(4'h1, 4'h1, 64'd0, 64'd0, 64'd0, 3'b001);
    tick;
    chk("nopfn_stat", 64'(out_stat), 64'd2);
    reset;
    drive(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 3'b001);
    tick;
    chk("jfn_stat", 64'(out_stat), 64'd2);
    reset;
    drive(4'h6, 4'h4, 64'd1, 64'd2, 64'd0, 3'b011);
    tick;
    chk("opfn_stat", 64'(out_stat), 64'd2);
    chk("opfn_cc", 64'(cc_q), 64'd4);
    reset;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 3'b011);
    tick;
    chk("nop_stat", 64'(out_stat), 64'd0);
    chk("nop_ready", 64'(in_ready), 64'd1);
`ifdef EXEC_CC_HOLD_EN
    cc_hold = 1'b1;
    drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 3'b011);
    tick;
    chk("hold_cc", 64'(cc_q), 64'd4);
    chk("hold_vale", out_vale, 64'd3);
    cc_hold = 1'b0;
    tick;
    chk("unhold_cc", 64'(cc_q), 64'd3);
`endif
    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
